// File: rtl/matrix_xfer_seq.sv
// Command-driven load/unload sequencer: one we/re strobe per matrix element; load has zero added latency,
// unload reads with 1-cycle latency into a 2-entry credit buffer, so re stalls whenever two elements are held or in flight.
module matrix_xfer_seq #(
  parameter int MAT_IDX_SIZE_MSB = 3,
  parameter int DATA_MSB         = 15
) (
  input  logic                      CLK,
  input  logic                      RST_L,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic [MAT_IDX_SIZE_MSB:0] cmd_row_idx_size,
  input  logic [MAT_IDX_SIZE_MSB:0] cmd_col_idx_size,
  output logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
  output logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_MSB:0]         in_data,
  output logic                      we,
  output logic [DATA_MSB:0]         wdata,
  output logic                      re,
  input  logic [DATA_MSB:0]         rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_MSB:0]         out_data,
  output logic                      done
);

  localparam int IW = MAT_IDX_SIZE_MSB + 1;
  localparam int RW = 2 * IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   remaining;
  logic [RW-1:0]   issue_left;
  logic [RW-1:0]   row_cnt;
  logic [RW-1:0]   col_cnt;
  logic [RW-1:0]   cmd_count;
  logic [1:0]      occ;
  logic            inflight;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            push;
  logic            pop;
  logic            last_xfer;
  logic [2:0]      outstanding;
  logic [DATA_MSB:0] skid_mem [2];

  assign row_cnt   = RW'(cmd_row_idx_size) + RW'(1);
  assign col_cnt   = RW'(cmd_col_idx_size) + RW'(1);
  assign cmd_count = row_cnt * col_cnt;

  assign we    = in_ready & in_valid;
  assign wdata = in_data;

  // Read data lands exactly one cycle after re; anything else on rdata is ignored.
  assign push      = inflight;
  assign out_valid = (occ != 2'd0);
  assign out_data  = skid_mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  // Credits: held + in flight after this cycle's pop must leave room for one more.
  assign outstanding = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign re          = (state == S_UNLOAD) && (issue_left != '0) && (outstanding < 3'd2);
  assign last_xfer   = (remaining == RW'(1));

  always_ff @(posedge CLK) begin
    if (push) begin
      skid_mem[wr_ptr] <= rdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      in_ready     <= 1'b0;
      done         <= 1'b0;
      row_idx_size <= '0;
      col_idx_size <= '0;
      remaining    <= '0;
      issue_left   <= '0;
      occ          <= 2'd0;
      inflight     <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
    end else begin
      inflight <= re;
      done     <= 1'b0;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state        <= cmd_op ? S_UNLOAD : S_LOAD;
            cmd_ready    <= 1'b0;
            in_ready     <= ~cmd_op;
            row_idx_size <= cmd_row_idx_size;
            col_idx_size <= cmd_col_idx_size;
            remaining    <= cmd_count;
            issue_left   <= cmd_count;
          end
        end
        S_LOAD: begin
          if (we) begin
            remaining <= remaining - RW'(1);
            if (last_xfer) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        S_UNLOAD: begin
          if (re) begin
            issue_left <= issue_left - RW'(1);
          end
          // Completion is counted on the output side so the buffer is drained first.
          if (pop) begin
            remaining <= remaining - RW'(1);
            if (last_xfer) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/matrix_xfer_seq.md
# matrix_xfer_seq

Command-driven transfer sequencer directly upstream of the matrix read/write control block. It accepts a load or unload command with matrix dimensions and generates exactly one `we` or `re` strobe per matrix element, so the control block's 2-D address counters return to the origin at the end of every transfer. Load elements arrive on a valid/ready input stream and are written in order. Unload elements are read with a one-cycle read latency and delivered through a 2-entry credit-controlled buffer to a valid/ready output stream.

## Interface
- `MAT_IDX_SIZE_MSB`, 3: MSB of the index-size fields. Index size = max index, so element count per dimension = size+1.
- `DATA_MSB`, 15: MSB of the element data.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST_L`  in  1: reset, asynchronous, active-low. Shared with the downstream counters.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  1: 0 = load (write), 1 = unload (read).
- `cmd_row_idx_size`, `cmd_col_idx_size`  in  MAT_IDX_SIZE_MSB+1: dimensions captured at acceptance.
- `row_idx_size`, `col_idx_size`  out  MAT_IDX_SIZE_MSB+1: registered dimensions driven to the control block.
- `in_valid`, `in_ready`, `in_data[DATA_MSB:0]`: load stream (in, out, in).
- `we`  out  1: write strobe. `wdata[DATA_MSB:0]` out: write data.
- `re`  out  1: read strobe. `rdata[DATA_MSB:0]` in: valid exactly one cycle after `re`.
- `out_valid`, `out_ready`, `out_data[DATA_MSB:0]`: unload stream (out, in, out).
- `done`  out  1: one-cycle pulse at the end of a transfer.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On handshake, go to LOAD or UNLOAD, latch the sizes, and load `remaining` = (row+1)*(col+1).
  - `remaining` is 2*(MAT_IDX_SIZE_MSB+1)+1 bits wide and is never zero at start (minimum 1 element, maximum 256 at defaults).
- LOAD:
  - `in_ready`=1.
  - `we` = `in_valid` (combinational), `wdata` = `in_data`.
  - Each handshake decrements `remaining`.
  - The handshake at `remaining`==1 goes to DONE.
- UNLOAD: per-cycle ordering of events.
  - `re` asserts when `issued` < total and (occ − pop + inflight) < 2.
    - occ: buffer occupancy (0..2).
    - pop: `out_valid && out_ready` in this cycle.
    - inflight: `re` from the previous cycle.
  - `rdata` is pushed into the buffer in the cycle after `re`.
  - `out_valid` = occ != 0. `out_data` = buffer head.
  - `remaining` decrements on each pop. The pop at `remaining`==1 goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `cmd_ready`=0 in DONE.
- Exclusivity:
  - `we` and `re` are never high in the same cycle.
  - `in_ready`=0 outside LOAD. `re`=0 outside UNLOAD.
- `row_idx_size`/`col_idx_size` hold their latched values until the next accepted command.
- The block issues exactly (row+1)*(col+1) strobes per transfer, never more.
- Buffer overflow is impossible by construction. A push into a full buffer is an assertion failure in the bench.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `in_ready`=0, `we`=0, `re`=0, `out_valid`=0, `done`=0, `row_idx_size`=`col_idx_size`=0, `remaining`=0, buffer empty.
- Command accepted at edge T → LOAD/UNLOAD active in cycle T+1.
- Load:
  - Zero added latency; `we` is in the same cycle as the input handshake.
  - Full throughput of 1 element/cycle.
- Unload:
  - First `re` in cycle T+1.
  - Data captured at the end of T+2.
  - `out_valid` first high in cycle T+3.
  - Sustains 1 element/cycle with `out_ready` held at 1.
- `out_ready` low: at most 2 elements are buffered or in flight, then `re` stalls. `out_valid`/`out_data` stay stable until accepted.
- `done`: the cycle after the last `we` (load) or after the last output pop (unload). `cmd_ready` is high again the following cycle.
- A command presented during a transfer waits. Sizes do not change mid-transfer.
- Reset mid-transfer: immediate return to reset values.
  - Buffered and in-flight data are discarded.
  - The downstream counters reset on the same `RST_L`, so addressing restarts at the origin.
- `rdata` is ignored in any cycle not following `re`.

## Test plan
- Load 2x3 (row=1, col=2) with `in_valid` held at 1 → exactly 6 `we` pulses in cycles T+1..T+6, `wdata` = inputs in order, `done` at T+7, `cmd_ready` at T+8.
- Unload 4x4 with `out_ready`=1 and memory model returning address-tagged data → 16 outputs in order, `re` continuous T+1..T+16, first `out_valid` T+3, `done` one cycle after the 16th pop.
- Unload 2x2 with `out_ready` toggling 1,0,0,1,… → never more than 2 elements outstanding, no data loss or duplication, exactly 4 `re` pulses.
- 1x1 load then 1x1 unload back-to-back, with the second `cmd_valid` held during the first transfer → second command accepted the cycle after `done`, exactly 1 `we` then 1 `re`.
- `RST_L` asserted mid-unload with 1 element buffered and 1 in flight → all outputs return to reset values asynchronously. A following 2x2 unload returns elements from address 0.
- Load with random `in_valid` gaps, then sizes changed on `cmd_*` during the transfer → `row_idx_size`/`col_idx_size` unchanged until the next acceptance, total `we` count correct.
